// File: rtl/avalon_st_pkg.sv
// Shared types for the result-to-Avalon-ST serialiser: FSM state encoding and default width.
package avalon_st_pkg;
  localparam int unsigned SZ_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;
endpackage

// File: rtl/avalon_st_result_source_if.sv
// Avalon-ST source bundle (readyLatency 0) carrying one half of a result per beat.
interface avalon_st_result_source_if
  import avalon_st_pkg::*;
#(
  parameter int unsigned SZ = SZ_DEFAULT
);
  logic [SZ-1:0] st_data;
  logic          st_valid;
  logic          st_ready;
  logic          st_sop;
  logic          st_eop;

  modport source (output st_data, output st_valid, output st_sop, output st_eop, input st_ready);
  modport sink   (input st_data, input st_valid, input st_sop, input st_eop, output st_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally, occupancy is explicit.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != DEPTH_C);
    pop_ok   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible once count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/avalon_st_result_source.sv
// Buffers 2*SZ-bit multiplier results and emits each as a two-beat Avalon-ST packet (low half first).
module avalon_st_result_source
  import avalon_st_pkg::*;
#(
  parameter int unsigned SZ    = SZ_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   _rst,
  input  logic [2*SZ-1:0]        res_in,
  input  logic                   res_valid,
  output logic                   res_accept,
  avalon_st_result_source_if.source st,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t           state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [2*SZ-1:0]  head;
  logic             push, pop;

  sync_fifo #(
    .WIDTH (2*SZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (_rst),
    .push    (push),
    .pop     (pop),
    .wr_data (res_in),
    .rd_data (head),
    .count   (count)
  );

  // Acceptance looks only at registered occupancy, keeping st_ready out of this path.
  assign res_accept = (count < DEPTH_C);
  assign push       = res_valid && res_accept;
  assign pop        = (state_q == HI) && st.st_ready;

  always_comb begin
    state_d     = state_q;
    st.st_valid = 1'b0;
    st.st_sop   = 1'b0;
    st.st_eop   = 1'b0;
    st.st_data  = '0;
    case (state_q)
      IDLE: begin
        if (count != '0) state_d = LO;
      end
      LO: begin
        st.st_valid = 1'b1;
        st.st_sop   = 1'b1;
        st.st_data  = head[SZ-1:0];
        if (st.st_ready) state_d = HI;
      end
      HI: begin
        st.st_valid = 1'b1;
        st.st_eop   = 1'b1;
        st.st_data  = head[2*SZ-1:SZ];
        if (st.st_ready) begin
          // A push landing on the popping edge keeps the stream gap-free.
          state_d = ((count > CW'(1)) || push) ? LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | (res_valid & ~res_accept);
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
endmodule

// File: tb/tb_avalon_st_result_source.sv
// Directed bench for avalon_st_result_source: SZ=32, DEPTH=4, outputs sampled on the falling edge.
module tb_avalon_st_result_source;
  localparam int unsigned SZ    = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] res_in;
  logic        res_valid;
  logic        res_accept;
  logic        overflow;
  logic [2:0]  count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [34:0] beat;

  always #5 clk = ~clk;

  avalon_st_result_source_if #(.SZ(SZ)) st_if ();

  avalon_st_result_source #(
    .SZ    (SZ),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    ._rst       (rst),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .res_accept (res_accept),
    .st         (st_if),
    .overflow   (overflow),
    .count      (count)
  );

  // {valid, sop, eop, data}
  assign beat = {st_if.st_valid, st_if.st_sop, st_if.st_eop, st_if.st_data};

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; res_in = '0; res_valid = 1'b0; st_if.st_ready = 1'b0;
    #2;
    vectors++; if (beat !== 35'h0) begin miscompares++; $display("FAIL reset_beat: got %h expected %h", beat, 35'h0); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (res_accept !== 1'b1) begin miscompares++; $display("FAIL reset_accept: got %b expected 1", res_accept); end
    @(negedge clk); tick;
    rst = 1'b0;
    tick;
    vectors++; if (res_accept !== 1'b1) begin miscompares++; $display("FAIL post_reset_accept: got %b expected 1", res_accept); end
    vectors++; if (beat !== 35'h0) begin miscompares++; $display("FAIL post_reset_beat: got %h expected %h", beat, 35'h0); end
  endtask

  task automatic test_single;
    res_in = 64'h0000000A_00000005; res_valid = 1'b1; st_if.st_ready = 1'b1;
    tick;
    res_valid = 1'b0;
    vectors++; if (beat !== 35'h0 || count !== 3'd1) begin miscompares++; $display("FAIL single_after_push: got beat %h count %0d expected beat 0 count 1", beat, count); end
    tick;
    vectors++; if (beat !== {3'b110, 32'h00000005}) begin miscompares++; $display("FAIL single_lo: got %h expected %h", beat, {3'b110, 32'h00000005}); end
    tick;
    vectors++; if (beat !== {3'b101, 32'h0000000A}) begin miscompares++; $display("FAIL single_hi: got %h expected %h", beat, {3'b101, 32'h0000000A}); end
    tick;
    vectors++; if (beat !== 35'h0 || count !== 3'd0) begin miscompares++; $display("FAIL single_done: got beat %h count %0d expected beat 0 count 0", beat, count); end
  endtask

  task automatic test_backpressure;
    st_if.st_ready = 1'b0; res_in = 64'h11112222_33334444; res_valid = 1'b1;
    tick;
    res_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (beat !== {3'b110, 32'h33334444}) begin miscompares++; $display("FAIL bp_hold_%0d: got %h expected %h", i, beat, {3'b110, 32'h33334444}); end
      tick;
    end
    st_if.st_ready = 1'b1;
    tick;
    vectors++; if (beat !== {3'b101, 32'h11112222}) begin miscompares++; $display("FAIL bp_hi: got %h expected %h", beat, {3'b101, 32'h11112222}); end
    tick;
    vectors++; if (beat !== 35'h0 || count !== 3'd0) begin miscompares++; $display("FAIL bp_done: got beat %h count %0d expected beat 0 count 0", beat, count); end
  endtask

  task automatic test_push_pop_same_cycle;
    st_if.st_ready = 1'b0; res_in = 64'hBEEF0001_BEEF0000; res_valid = 1'b1;
    tick;
    res_valid = 1'b0;
    tick;
    st_if.st_ready = 1'b1;
    tick;
    vectors++; if (beat !== {3'b101, 32'hBEEF0001} || count !== 3'd1) begin miscompares++; $display("FAIL same_hi: got beat %h count %0d expected beat %h count 1", beat, count, {3'b101, 32'hBEEF0001}); end
    res_in = 64'hCAFE0001_CAFE0000; res_valid = 1'b1;
    tick;
    res_valid = 1'b0;
    vectors++; if (beat !== {3'b110, 32'hCAFE0000} || count !== 3'd1) begin miscompares++; $display("FAIL same_lo: got beat %h count %0d expected beat %h count 1", beat, count, {3'b110, 32'hCAFE0000}); end
    tick;
    vectors++; if (beat !== {3'b101, 32'hCAFE0001}) begin miscompares++; $display("FAIL same_hi2: got %h expected %h", beat, {3'b101, 32'hCAFE0001}); end
    tick;
    vectors++; if (beat !== 35'h0 || count !== 3'd0) begin miscompares++; $display("FAIL same_done: got beat %h count %0d expected beat 0 count 0", beat, count); end
  endtask

  task automatic test_fill_overflow;
    st_if.st_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        vectors++; if (count !== 3'd4 || res_accept !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL fill_full: got count %0d accept %b ovf %b expected 4 0 0", count, res_accept, overflow); end
      end
      res_in = {32'h200 + 32'(k), 32'h100 + 32'(k)}; res_valid = 1'b1;
      tick;
    end
    res_valid = 1'b0;
    vectors++; if (count !== 3'd4 || res_accept !== 1'b0 || overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow: got count %0d accept %b ovf %b expected 4 0 1", count, res_accept, overflow); end
    st_if.st_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (beat !== {3'b110, 32'h100 + 32'(k)}) begin miscompares++; $display("FAIL drain_lo_%0d: got %h expected %h", k, beat, {3'b110, 32'h100 + 32'(k)}); end
      tick;
      vectors++; if (beat !== {3'b101, 32'h200 + 32'(k)}) begin miscompares++; $display("FAIL drain_hi_%0d: got %h expected %h", k, beat, {3'b101, 32'h200 + 32'(k)}); end
      tick;
    end
    vectors++; if (beat !== 35'h0 || count !== 3'd0 || overflow !== 1'b1) begin miscompares++; $display("FAIL drain_done: got beat %h count %0d ovf %b expected 0 0 1", beat, count, overflow); end
  endtask

  task automatic test_streaming;
    int idx;
    int b;
    idx = 0;
    st_if.st_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        b = c - 2;
        if (b % 2 == 0) begin
          vectors++; if (beat !== {3'b110, 32'h30000000 + 32'(b / 2)}) begin miscompares++; $display("FAIL stream_lo_%0d: got %h expected %h", b, beat, {3'b110, 32'h30000000 + 32'(b / 2)}); end
        end else begin
          vectors++; if (beat !== {3'b101, 32'h40000000 + 32'(b / 2)}) begin miscompares++; $display("FAIL stream_hi_%0d: got %h expected %h", b, beat, {3'b101, 32'h40000000 + 32'(b / 2)}); end
        end
        vectors++; if (count > 3'd1) begin miscompares++; $display("FAIL stream_count_%0d: got %0d expected at most 1", b, count); end
      end
      res_valid = (c == 0) || (c == 3) || (c == 5) || (c == 7);
      res_in    = {32'h40000000 + 32'(idx), 32'h30000000 + 32'(idx)};
      if (res_valid) idx++;
      tick;
    end
    res_valid = 1'b0;
    vectors++; if (beat !== 35'h0 || count !== 3'd0) begin miscompares++; $display("FAIL stream_done: got beat %h count %0d expected beat 0 count 0", beat, count); end
  endtask

  task automatic test_reset_mid;
    st_if.st_ready = 1'b0; res_valid = 1'b1;
    res_in = 64'h0000AAAA_0000A000; tick;
    res_in = 64'h0000BBBB_0000B000; tick;
    res_in = 64'h0000CCCC_0000C000; st_if.st_ready = 1'b1; tick;
    res_valid = 1'b0; st_if.st_ready = 1'b0;
    vectors++; if (beat !== {3'b101, 32'h0000AAAA} || count !== 3'd3) begin miscompares++; $display("FAIL mid_pre: got beat %h count %0d expected %h count 3", beat, count, {3'b101, 32'h0000AAAA}); end
    rst = 1'b1;
    #1;
    vectors++; if (beat !== 35'h0) begin miscompares++; $display("FAIL mid_async_beat: got %h expected %h", beat, 35'h0); end
    vectors++; if (count !== 3'd0 || overflow !== 1'b0 || res_accept !== 1'b1) begin miscompares++; $display("FAIL mid_async_state: got count %0d ovf %b accept %b expected 0 0 1", count, overflow, res_accept); end
    @(negedge clk);
    rst = 1'b0;
    st_if.st_ready = 1'b1;
    tick; tick;
    vectors++; if (beat !== 35'h0 || count !== 3'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL mid_after: got beat %h count %0d ovf %b expected 0 0 0", beat, count, overflow); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_push_pop_same_cycle;
    test_fill_overflow;
    test_streaming;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
